// File: rtl/blink_rtc.sv
// Blink RTC: tick prescaler, TIM0/TIM1/minute cascade, sticky status,
// minute alarm and coherent snapshot read of the multi-byte time.
module blink_rtc #(
  parameter int TICK_DIV      = 49152,
  parameter int TICKS_PER_SEC = 200,
  parameter int SEC_PER_MIN   = 60,
  parameter int MIN_WIDTH     = 21
) (
  input  logic       mck,
  input  logic       rin,
  input  logic       restim,
  input  logic       reg_wr,
  input  logic       reg_rd,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       rd_hit,
  output logic       rtc_int,
  output logic       t_1s,
  output logic       t_5ms
);

  localparam int TCK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TCK_W-1:0]     tck_q, tck_d;
  logic [7:0]           tim0_q, tim0_d;
  logic [5:0]           tim1_q, tim1_d;
  logic [MIN_WIDTH-1:0] timm_q, timm_d;
  logic [3:0]           tsta_q, tsta_d;
  logic [3:0]           tmk_q, tmk_d;
  logic [15:0]          alm_q, alm_d;
  logic                 alm_en_q, alm_en_d;
  logic [5:0]           snap_tim1_q, snap_tim1_d;
  logic [MIN_WIDTH-1:0] snap_timm_q, snap_timm_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rd_hit_q, rd_hit_d;

  logic                 tick;
  logic                 sec_wrap;
  logic                 min_wrap;
  logic [MIN_WIDTH-1:0] timm_inc;
  logic [23:0]          timm_inc_ext;
  logic [23:0]          snap_ext;
  logic [3:0]           set;
  logic [3:0]           clr;

  always_comb begin
    tck_d       = tck_q;
    tim0_d      = tim0_q;
    tim1_d      = tim1_q;
    timm_d      = timm_q;
    tmk_d       = tmk_q;
    alm_d       = alm_q;
    alm_en_d    = alm_en_q;
    snap_tim1_d = snap_tim1_q;
    snap_timm_d = snap_timm_q;
    rdata_d     = rdata_q;
    rd_hit_d    = 1'b0;
    set         = 4'b0;
    clr         = 4'b0;

    tick         = !restim && (tck_q == TCK_W'(TICK_DIV - 1));
    sec_wrap     = (tim0_q == 8'(TICKS_PER_SEC - 1));
    min_wrap     = (tim1_q == 6'(SEC_PER_MIN - 1));
    timm_inc     = timm_q + MIN_WIDTH'(1);
    timm_inc_ext = 24'(timm_inc);
    snap_ext     = 24'(snap_timm_q);

    if (restim) begin
      tck_d  = '0;
      tim0_d = '0;
      tim1_d = '0;
      timm_d = '0;
    end else if (tick) begin
      tck_d  = '0;
      set[0] = 1'b1;
      if (sec_wrap) begin
        tim0_d = '0;
        set[1] = 1'b1;
        if (min_wrap) begin
          tim1_d = '0;
          timm_d = timm_inc;
          set[2] = 1'b1;
          set[3] = alm_en_q && (timm_inc_ext[15:0] == alm_q);
        end else begin
          tim1_d = tim1_q + 6'd1;
        end
      end else begin
        tim0_d = tim0_q + 8'd1;
      end
    end else begin
      tck_d = tck_q + TCK_W'(1);
    end

    if (reg_wr) begin
      case (addr)
        8'hB4: clr = wdata[3:0];
        8'hB5: tmk_d = wdata[3:0];
        8'hD5: alm_d[7:0] = wdata;
        8'hD6: alm_d[15:8] = wdata;
        8'hD7: alm_en_d = wdata[0];
        default: ;
      endcase
    end

    // set is ORed after the clear so a same-cycle event is never lost
    tsta_d = (tsta_q & ~clr) | set;

    if (reg_rd) begin
      rd_hit_d = 1'b1;
      case (addr)
        8'hB5: rdata_d = {4'b0, tsta_q};
        8'hD0: begin
          rdata_d     = tim0_q;
          snap_tim1_d = tim1_q;
          snap_timm_d = timm_q;
        end
        8'hD1: rdata_d = {2'b0, snap_tim1_q};
        8'hD2: rdata_d = snap_ext[7:0];
        8'hD3: rdata_d = snap_ext[15:8];
        8'hD4: rdata_d = snap_ext[23:16];
        8'hD5: rdata_d = alm_q[7:0];
        8'hD6: rdata_d = alm_q[15:8];
        8'hD7: rdata_d = {7'b0, alm_en_q};
        default: rd_hit_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge mck) begin
    if (rin) begin
      tck_q       <= '0;
      tim0_q      <= '0;
      tim1_q      <= '0;
      timm_q      <= '0;
      tsta_q      <= '0;
      tmk_q       <= '0;
      alm_q       <= '0;
      alm_en_q    <= 1'b0;
      snap_tim1_q <= '0;
      snap_timm_q <= '0;
      rdata_q     <= '0;
      rd_hit_q    <= 1'b0;
    end else begin
      tck_q       <= tck_d;
      tim0_q      <= tim0_d;
      tim1_q      <= tim1_d;
      timm_q      <= timm_d;
      tsta_q      <= tsta_d;
      tmk_q       <= tmk_d;
      alm_q       <= alm_d;
      alm_en_q    <= alm_en_d;
      snap_tim1_q <= snap_tim1_d;
      snap_timm_q <= snap_timm_d;
      rdata_q     <= rdata_d;
      rd_hit_q    <= rd_hit_d;
    end
  end

  assign rdata   = rdata_q;
  assign rd_hit  = rd_hit_q;
  assign rtc_int = |(tsta_q & tmk_q);
  assign t_1s    = tim0_q[7];
  assign t_5ms   = tim0_q[1];

endmodule

// File: tb/tb_blink_rtc.sv
// Bench for blink_rtc: directed cascade/race/snapshot/alarm/restim/reset
// steps, then random register traffic against a tick-count reference model.
module tb_blink_rtc;

  localparam int TD  = 4;
  localparam int TPS = 4;
  localparam int SPM = 3;
  localparam int MW  = 21;
  localparam int CPM = TD * TPS * SPM;

  logic       mck    = 1'b0;
  logic       rin    = 1'b1;
  logic       restim = 1'b0;
  logic       reg_wr = 1'b0;
  logic       reg_rd = 1'b0;
  logic [7:0] addr   = 8'h00;
  logic [7:0] wdata  = 8'h00;
  logic [7:0] rdata;
  logic       rd_hit;
  logic       rtc_int;
  logic       t_1s;
  logic       t_5ms;

  blink_rtc #(
    .TICK_DIV(TD), .TICKS_PER_SEC(TPS),
    .SEC_PER_MIN(SPM), .MIN_WIDTH(MW)
  ) dut (
    .mck(mck), .rin(rin), .restim(restim),
    .reg_wr(reg_wr), .reg_rd(reg_rd),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .rd_hit(rd_hit),
    .rtc_int(rtc_int), .t_1s(t_1s), .t_5ms(t_5ms)
  );

  always #5 mck = ~mck;

  int compared   = 0;
  int mismatched = 0;

  // model state: n = counting edges since counters last started from 0
  int unsigned n      = 0;
  logic [3:0]  m_tsta = 0;
  logic [3:0]  m_tmk  = 0;
  logic [15:0] m_alm  = 0;
  logic        m_alm_en = 0;
  int unsigned m_s1   = 0;
  int unsigned m_sm   = 0;
  logic [7:0]  m_rdata = 0;
  logic        m_hit  = 0;

  function automatic int unsigned f_tim0(int unsigned k);
    return (k / TD) % TPS;
  endfunction
  function automatic int unsigned f_tim1(int unsigned k);
    return (k / (TD * TPS)) % SPM;
  endfunction
  function automatic int unsigned f_timm(int unsigned k);
    return (k / CPM) % (1 << MW);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [3:0]  set;
    logic [3:0]  clr;
    logic [7:0]  t0;
    int unsigned tk;
    set = 4'b0;
    clr = 4'b0;
    if (rin) begin
      n = 0; m_tsta = 0; m_tmk = 0; m_alm = 0; m_alm_en = 0;
      m_s1 = 0; m_sm = 0; m_rdata = 0; m_hit = 0;
    end else begin
      if (!restim && ((n + 1) % TD == 0)) begin
        tk = (n + 1) / TD;
        set[0] = 1'b1;
        if (tk % TPS == 0) set[1] = 1'b1;
        if (tk % (TPS * SPM) == 0) begin
          set[2] = 1'b1;
          if (m_alm_en && (16'(f_timm(n + 1)) == m_alm)) set[3] = 1'b1;
        end
      end
      m_hit = 1'b0;
      if (reg_rd) begin
        m_hit = 1'b1;
        case (addr)
          8'hB5: m_rdata = {4'b0, m_tsta};
          8'hD0: begin
            m_rdata = 8'(f_tim0(n));
            m_s1 = f_tim1(n);
            m_sm = f_timm(n);
          end
          8'hD1: m_rdata = 8'(m_s1);
          8'hD2: m_rdata = 8'(m_sm);
          8'hD3: m_rdata = 8'(m_sm >> 8);
          8'hD4: m_rdata = 8'(m_sm >> 16);
          8'hD5: m_rdata = m_alm[7:0];
          8'hD6: m_rdata = m_alm[15:8];
          8'hD7: m_rdata = {7'b0, m_alm_en};
          default: m_hit = 1'b0;
        endcase
      end
      if (reg_wr) begin
        case (addr)
          8'hB4: clr = wdata[3:0];
          8'hB5: m_tmk = wdata[3:0];
          8'hD5: m_alm[7:0] = wdata;
          8'hD6: m_alm[15:8] = wdata;
          8'hD7: m_alm_en = wdata[0];
          default: ;
        endcase
      end
      m_tsta = (m_tsta & ~clr) | set;
      n = restim ? 0 : n + 1;
    end
    @(posedge mck);
    #1;
    t0 = 8'(f_tim0(n));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("rd_hit", 32'(rd_hit), 32'(m_hit));
    chk("rtc_int", 32'(rtc_int), 32'(|(m_tsta & m_tmk)));
    chk("t_1s", 32'(t_1s), 32'(t0[7]));
    chk("t_5ms", 32'(t_5ms), 32'(t0[1]));
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    addr = a; wdata = d; reg_wr = 1'b1;
    step();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    addr = a; reg_rd = 1'b1;
    step();
    reg_rd = 1'b0;
    v = rdata;
  endtask

  logic [7:0]  v;
  logic [3:0]  saved;
  int unsigned mold;
  logic [7:0]  atab [10];

  initial begin
    atab = '{8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2,
             8'hD3, 8'hD5, 8'hD6, 8'hD7, 8'hA0};
    rin = 1'b1;
    step(); step();
    chk("reset_rdata", 32'(rdata), 32'h0);
    chk("reset_int", 32'(rtc_int), 32'h0);
    rin = 1'b0;

    // cascade: first tick at the 4th edge
    step(); step(); step();
    rd(8'hB5, v); chk("tsta_pre_tick", 32'(v), 32'h0);
    rd(8'hB5, v); chk("tsta_tick", 32'(v), 32'h1);
    while (n < 17) step();
    rd(8'hD0, v);
    rd(8'hD1, v); chk("tim1_after16", 32'(v), 32'h1);
    while (n < 49) step();
    rd(8'hD0, v);
    rd(8'hD2, v); chk("timm_after48", 32'(v), 32'h1);
    rd(8'hB5, v); chk("tsta_cascade", 32'(v), 32'h7);
    while (n % TD != 0) step();
    wr(8'hB4, 8'h07);
    rd(8'hB5, v); chk("tsta_ack", 32'(v), 32'h0);

    // set-vs-clear race
    wr(8'hB5, 8'h01);
    while (n % TD != TD - 1) step();
    wr(8'hB4, 8'h01);
    chk("race_int", 32'(rtc_int), 32'h1);
    rd(8'hB5, v); chk("race_tsta0", 32'(v[0]), 32'h1);

    // snapshot coherence one cycle before the minute rollover
    while ((n + 1) % CPM != 0) step();
    mold = f_timm(n);
    rd(8'hD0, v); chk("snap_tim0", 32'(v), 32'h3);
    step();
    rd(8'hD1, v); chk("snap_tim1", 32'(v), 32'h2);
    rd(8'hD2, v); chk("snap_timm", 32'(v), 32'(8'(mold)));

    // reset mid-operation
    rin = 1'b1;
    step();
    rin = 1'b0;
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_hit", 32'(rd_hit), 32'h0);
    chk("rst_int", 32'(rtc_int), 32'h0);
    chk("rst_t1s", 32'({t_1s, t_5ms}), 32'h0);
    rd(8'hD1, v); chk("rst_snap", 32'(v), 32'h0);

    // alarm at minute 2
    wr(8'hD5, 8'h02); wr(8'hD6, 8'h00);
    wr(8'hD7, 8'h01); wr(8'hB5, 8'h08);
    while (n < 2 * CPM + 2) step();
    rd(8'hB5, v); chk("alarm_tsta", 32'(v), 32'hF);
    chk("alarm_int", 32'(rtc_int), 32'h1);
    wr(8'hD7, 8'h00); wr(8'hD5, 8'h03); wr(8'hB4, 8'h0F);
    while (n < 3 * CPM + 2) step();
    rd(8'hB5, v); chk("alarm_off_tsta", 32'(v), 32'h7);
    chk("alarm_off_int", 32'(rtc_int), 32'h0);

    // restim holds counters, keeps status
    while (n % TD != 1) step();
    saved = m_tsta;
    restim = 1'b1;
    repeat (5) step();
    rd(8'hD0, v); chk("restim_tim0", 32'(v), 32'h0);
    rd(8'hD1, v); chk("restim_tim1", 32'(v), 32'h0);
    rd(8'hD2, v); chk("restim_timm", 32'(v), 32'h0);
    rd(8'hB5, v); chk("restim_tsta", 32'(v), 32'(saved));
    rd(8'hB5, v); chk("restim_tmk", 32'(m_tmk), 32'h8);
    restim = 1'b0;
    repeat (4) step();
    rd(8'hD0, v); chk("restim_resume", 32'(v), 32'h1);

    // random register traffic
    for (int i = 0; i < 600; i++) begin
      restim = ($urandom_range(0, 24) == 0);
      reg_wr = ($urandom_range(0, 3) == 0);
      reg_rd = ($urandom_range(0, 2) == 0);
      addr   = atab[$urandom_range(0, 9)];
      wdata  = 8'($urandom);
      step();
      reg_wr = 1'b0;
      reg_rd = 1'b0;
      restim = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/blink_rtc.md
Name: blink_rtc

Overview:
Parametrised real-time-clock and timer-interrupt unit for the Blink gate array. It replaces the fixed-constant tick, TIM0..TIM4 and TSTA/TMK logic of the current Blink with a standalone block. New capabilities over the current Blink:
- coherent snapshot read of the multi-byte time;
- programmable minute alarm with its own status bit;
- defined set/clear priority.
It sits on the Blink I/O register strobes and drives the RTC interrupt request and the screen flash/grey lines.

Parameters:
TICK_DIV, 49152, mck cycles per tick; tick counter counts 0..TICK_DIV-1.
TICKS_PER_SEC, 200, ticks per second (TIM0 range 0..TICKS_PER_SEC-1, must be <=256).
SEC_PER_MIN, 60, seconds per minute (TIM1 range, must be <=64).
MIN_WIDTH, 21, minute counter width (8 < MIN_WIDTH <= 24).

Ports:
mck  in  1  master clock; all logic on rising edge.
rin  in  1  synchronous active-high reset.
restim  in  1  COM bit 4; while high, tick/TIM counters held at 0.
reg_wr  in  1  one-cycle I/O write strobe.
reg_rd  in  1  one-cycle I/O read strobe.
addr  in  8  I/O port address (low byte).
wdata  in  8  write data.
rdata  out  8  registered read data.
rd_hit  out  1  high 1 cycle after reg_rd to a port this block decodes.
rtc_int  out  1  |(tsta & tmk), combinational from registers.
t_1s  out  1  TIM0 bit 7.
t_5ms  out  1  TIM0 bit 1.

Behaviour:
- Reset (rin=1): tck, tim0, tim1, timm, tsta, tmk, alm, alm_en, snapshot and rdata = 0; rd_hit = 0.
- restim=1 clears tck, tim0, tim1 and timm only; tsta, tmk and alarm are kept. No events are generated while restim=1.
- tck increments every cycle. At tck==TICK_DIV-1: tck<=0, tick event.
- On a tick: tim0 increments and tsta[0] is set.
  - If tim0==TICKS_PER_SEC-1: tim0<=0, tim1 increments, tsta[1] set.
  - If tim1 also ==SEC_PER_MIN-1: tim1<=0, timm increments (wraps at 2^MIN_WIDTH), tsta[2] set.
- Alarm: on a minute increment, if alm_en and the new timm[15:0]==alm, then tsta[3] is set in the same cycle as tsta[2].
- tsta is 4 bits, sticky. Write TACK (0xB4): each wdata[i]=1 clears tsta[i], i=0..3.
  - If the same cycle sets the bit, set wins; the event is never lost.
- Register writes, all taking effect on the next edge:
  - 0xB5 TMK: tmk<=wdata[3:0].
  - 0xD5: alm[7:0].
  - 0xD6: alm[15:8].
  - 0xD7: alm_en<=wdata[0].
- Register reads: rdata is loaded on the edge where reg_rd=1, and holds its value otherwise. rd_hit pulses on the same edge.
  - 0xB5 TSTA: {4'b0, tsta}.
  - 0xD0 TIM0: returns live tim0. The same edge captures snap_tim1 = tim1 and snap_timm = timm (the post-increment values if a tick lands that cycle are not used; capture the pre-edge values, consistent with tim0 returned).
  - 0xD1: {2'b0, snap_tim1}.
  - 0xD2: snap_timm[7:0].
  - 0xD3: snap_timm[15:8].
  - 0xD4: snap_timm[MIN_WIDTH-1:16], zero-extended.
  - 0xD5/0xD6/0xD7: alm low byte, alm high byte, {7'b0, alm_en}.
  - Any other address: rdata unchanged, rd_hit=0.
- Reads D1..D4 without a prior D0 read return the last snapshot (0 after reset).
- reg_wr and reg_rd in the same cycle: both are honoured independently.
- rtc_int follows tsta/tmk combinationally; no extra latency.

Test Plan:
- Counter cascade: TICK_DIV=4, TICKS_PER_SEC=4, SEC_PER_MIN=3; release rin.
  - tsta[0] sets at cycle 4.
  - tim1=1 and tsta[1] after 16 cycles.
  - timm=1 and tsta[2] after 48 cycles.
  - After TACK 0x07, tsta=0.
- Set-vs-clear race: issue TACK 0x01 in the exact cycle of a tick -> tsta[0] remains 1 and rtc_int stays 1 with tmk=0x1.
- Snapshot coherence: read D0 with tim0=3 and tim1=2 (one cycle before the minute rollover), then wait 1 cycle. Read D1 -> 0x02, not 0x00. Read D2 -> old minute.
- Alarm: write D5=0x02, D6=0x00, D7=0x01, TMK=0x08.
  - After the 2nd minute: tsta=0x0F and rtc_int=1.
  - With alm_en=0, tsta[3] stays 0.
- restim: assert mid-count -> tim0/tim1/timm read 0, tsta and tmk unchanged, no new tsta bits set. Deassert -> counting resumes from 0.
- Reset mid-operation: rin=1 for 1 cycle with nonzero state -> all registers, rdata, rtc_int, t_1s and t_5ms are 0 on the next cycle.
